uart_hex_logger: RTL

//  Upstream feeder for the UART transmit path. Captures WIDTH-bit log words
//  (e.g. SPI address/opcode records) into a small FIFO and prints each one as

---
 rtl/uart_hex_logger_if.sv | 24 ++
 rtl/uart_hex_logger.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_hex_logger_if.sv
// Log-word input and UART character handshake bundle for uart_hex_logger.
// slave = the logger itself, master = whoever feeds words and owns the UART.
interface uart_hex_logger_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       drop_count;
  logic             busy;
  logic [7:0]       txd;
  logic             txd_strobe;
  logic             txd_ready;

  modport slave (
    input  in_data, in_valid, txd_ready,
    output in_ready, drop_count, busy, txd, txd_strobe
  );

  modport master (
    output in_data, in_valid, txd_ready,
    input  in_ready, drop_count, busy, txd, txd_strobe
  );
endinterface

// File: rtl/uart_hex_logger.sv
// Buffers WIDTH-bit log words in a small FIFO and prints each as lowercase hex
// plus end-of-line over the UART handshake. Define UART_HEX_LOGGER_CRLF_EN for "\r\n".
module uart_hex_logger #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_hex_logger_if.slave bus
);
  localparam int DIGITS = WIDTH / 4;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIGIT,
`ifdef UART_HEX_LOGGER_CRLF_EN
    S_CR,
`endif
    S_LF
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       drop_q;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [7:0]       txd_q, txd_d;
  logic             strobe_q, strobe_d;
  logic             full, empty, wr_en, pop, send;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Fullness is taken before this cycle's pop, so a write at full always drops.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = bus.in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  // The UART lowers ready one cycle late; skipping the cycle after a strobe avoids a double send.
  assign send  = bus.txd_ready && !strobe_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (bus.in_valid && full && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      txd_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      txd_q    <= txd_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!empty) state_d = S_LOAD;
      S_LOAD:  state_d = S_DIGIT;
      S_DIGIT: begin
        if (send && (cnt_q == '0)) begin
`ifdef UART_HEX_LOGGER_CRLF_EN
          state_d = S_CR;
`else
          state_d = S_LF;
`endif
        end
      end
`ifdef UART_HEX_LOGGER_CRLF_EN
      S_CR:    if (send) state_d = S_LF;
`endif
      S_LF:    if (send) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    txd_d    = txd_q;
    strobe_d = 1'b0;
    unique case (state_q)
      S_IDLE:  if (!empty) shift_d = mem_q[rd_ptr_q];
      S_LOAD:  cnt_d = DW'(DIGITS - 1);
      S_DIGIT: begin
        if (send) begin
          txd_d    = hex_char(shift_q[WIDTH-1 -: 4]);
          strobe_d = 1'b1;
          shift_d  = shift_q << 4;
          cnt_d    = cnt_q - DW'(1);
        end
      end
`ifdef UART_HEX_LOGGER_CRLF_EN
      S_CR: begin
        if (send) begin
          txd_d    = 8'h0D;
          strobe_d = 1'b1;
        end
      end
`endif
      S_LF: begin
        if (send) begin
          txd_d    = 8'h0A;
          strobe_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready   = !full;
  assign bus.drop_count = drop_q;
  assign bus.busy       = !empty || (state_q != S_IDLE);
  assign bus.txd        = txd_q;
  assign bus.txd_strobe = strobe_q;
endmodule
